// File: rtl/step_clock_gen_if.sv
// rtl/step_clock_gen_if.sv - key/switch inputs and step outputs of the step clock generator
interface step_clock_gen_if;
    logic        key_n;
    logic        run_sw;
    logic        step_pulse;
    logic        key_level;
    logic        run_active;
    logic [15:0] step_count;

    modport master (
        output key_n,
        output run_sw,
        input  step_pulse,
        input  key_level,
        input  run_active,
        input  step_count
    );

    modport slave (
        input  key_n,
        input  run_sw,
        output step_pulse,
        output key_level,
        output run_active,
        output step_count
    );
endinterface

// File: rtl/step_clock_gen.sv
// rtl/step_clock_gen.sv - debounced single-step / free-run step pulse generator
// Optional step counter built only when STEP_COUNT_EN is defined.
module step_clock_gen #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int RUN_DIV         = 25000000
) (
    input  logic              clk,
    input  logic              reset,
    step_clock_gen_if.slave   bus
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] HELD         = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    logic             key_s1, key_s2;
    logic             run_s1, run_s2;
    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             press_nxt;
    logic             press_evt;
    logic [DIV_W-1:0] div;
    logic             div_hit;
    logic             step_pulse_q;
    logic             key_level_q;

    // Idle values: key released (high), run switch off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
            run_s1 <= 1'b0;
            run_s2 <= 1'b0;
        end else begin
            key_s1 <= bus.key_n;
            key_s2 <= key_s1;
            run_s1 <= bus.run_sw;
            run_s2 <= run_s1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (!key_s2) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (key_s2) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HELD;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HELD: begin
                if (key_s2) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (!key_s2) begin
                    state_nxt = HELD;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // key_level is registered from the next state so it tracks the state exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            press_evt   <= 1'b0;
            key_level_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            press_evt   <= press_nxt;
            key_level_q <= (state_nxt == HELD) || (state_nxt == RELEASE_WAIT);
        end
    end

    assign div_hit = run_s2 && (div == DIV_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div          <= '0;
            step_pulse_q <= 1'b0;
        end else begin
            if (!run_s2 || div_hit) begin
                div <= '0;
            end else begin
                div <= div + 1'b1;
            end
            // Key events only count in single-step mode; OR merges coincident sources.
            step_pulse_q <= div_hit | (press_evt & ~run_s2);
        end
    end

    assign bus.step_pulse = step_pulse_q;
    assign bus.key_level  = key_level_q;
    assign bus.run_active = run_s2;

`ifdef STEP_COUNT_EN
    logic [15:0] step_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_count_q <= 16'h0000;
        end else if (step_pulse_q) begin
            step_count_q <= step_count_q + 16'h0001;
        end
    end

    assign bus.step_count = step_count_q;
`else
    assign bus.step_count = 16'h0000;
`endif

endmodule

// File: doc/step_clock_gen.md
STEP_CLOCK_GEN -- requirements
Module: step_clock_gen

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, number of consecutive stable synchronized samples needed to accept a key press or release.
REQ-002 Parameter RUN_DIV, default 25000000, clk cycles between step pulses in free-run mode.
REQ-003 clk  input  1  single system clock; all state SHALL be clocked on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 key_n  input  1  raw active-low push button (0 = pressed), asynchronous and bouncing.
REQ-006 run_sw  input  1  raw slide switch; 1 selects free-run mode, 0 selects single-step mode.
REQ-007 step_pulse  output  1  one-cycle clock-enable pulse that advances the processor by one step.
REQ-008 key_level  output  1  debounced key state (1 = pressed).
REQ-009 run_active  output  1  synchronized run_sw level currently in effect.
REQ-010 step_count  output  16  number of step_pulse assertions since reset.

Function
REQ-011 key_n and run_sw SHALL each pass through a two-flop synchronizer before any other use.
REQ-012 Debounce FSM states SHALL be IDLE, PRESS_WAIT, HELD and RELEASE_WAIT, with IDLE as the reset state.
REQ-013 IDLE -> PRESS_WAIT on a synchronized low sample, with the stability counter cleared.
REQ-014 PRESS_WAIT: a high sample returns to IDLE. DEBOUNCE_CYCLES consecutive low samples move to HELD.
REQ-015 HELD -> RELEASE_WAIT on a synchronized high sample, with the counter cleared.
REQ-016 RELEASE_WAIT: a low sample returns to HELD. DEBOUNCE_CYCLES consecutive high samples move to IDLE.
REQ-017 key_level SHALL be 1 exactly while the state is HELD or RELEASE_WAIT.
REQ-018 Single-step mode (run_active=0): step_pulse SHALL be high for exactly one cycle, in the cycle after the PRESS_WAIT->HELD transition.
REQ-019 With key_n held low and clean, step_pulse SHALL be high on the (DEBOUNCE_CYCLES+3)th rising edge after the edge that first samples key_n low.
REQ-020 A key held indefinitely SHALL produce exactly one pulse; no auto-repeat.
REQ-021 Free-run mode: a divider SHALL count 0..RUN_DIV-1 and assert step_pulse for one cycle when it equals RUN_DIV-1, then wrap to 0.
REQ-022 The divider SHALL be held at 0 while run_active=0, so the first free-run pulse comes RUN_DIV cycles after run_active rises.
REQ-023 The debounce FSM SHALL keep tracking the key in free-run mode, but key-derived pulses SHALL be suppressed there.
REQ-024 When a key pulse and a divider pulse fall in the same cycle, step_pulse SHALL be a single one-cycle pulse.
REQ-025 If run_active falls mid-count, the divider SHALL clear on the next edge and produce no further pulse.
REQ-026 step_count SHALL increment by 1 on every cycle step_pulse is high, wrapping from 0xFFFF to 0x0000.
REQ-027 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Reset
REQ-028 Asserting reset SHALL immediately force the following, whatever the clk activity:
 - FSM to IDLE
 - synchronizer flops to their idle values (key = released, run = 0)
 - debounce counter and divider to 0
 - step_pulse=0, key_level=0, run_active=0, step_count=0x0000
REQ-029 Reset asserted mid-debounce or mid-divide SHALL discard partial counts; after release, a new press needs the full DEBOUNCE_CYCLES again.
REQ-030 A key already held low when reset deasserts SHALL produce one pulse after the full debounce interval.

Configuration
REQ-031 Macro STEP_COUNT_EN SHALL control whether the step_count counter is built.
REQ-032 With STEP_COUNT_EN defined, step_count SHALL behave as in REQ-026.
REQ-033 Without STEP_COUNT_EN, the step_count port SHALL remain and be tied to 0x0000, with no counter logic built; all other behaviour is unchanged.

Verification (DEBOUNCE_CYCLES=4, RUN_DIV=8)
REQ-034 Clean press: hold key_n=0 -> one step_pulse on edge 7 after first low sample, key_level=1, step_count=1.
REQ-035 Bounce: key_n toggles 0,1,0,1 every cycle, then held 0 -> no pulse during toggling, exactly one pulse 7 edges after the final low.
REQ-036 Free-run: run_sw=1 for 40 cycles -> pulses every 8 cycles, first at cycle 8 after run_active rises; key presses add no pulses.
REQ-037 Wrap and reset: preload 0xFFFF steps, then one press -> step_count=0x0000. Assert reset mid-PRESS_WAIT -> outputs 0 at once, no pulse.
REQ-038 Macro off: build without STEP_COUNT_EN and repeat REQ-034 -> identical step_pulse timing, step_count stays 0x0000.
